// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes one 16-bit instruction, checks a pending-write scoreboard, loads the ID/EX register.
// Optional WB_BYPASS_EN: a writeback in the issue cycle resolves the hazard and forwards wb_data into the operands.
module decode_issue_stage #(
  parameter int NREGS = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [15:0]   in_instr,
  output logic          in_ready,
  input  logic          flush,
  output logic [3:0]    SrcReg1,
  output logic [3:0]    SrcReg2,
  input  logic [DW-1:0] SrcData1,
  input  logic [DW-1:0] SrcData2,
  input  logic          wb_en,
  input  logic [3:0]    wb_reg,
  input  logic [DW-1:0] wb_data,
  output logic          WriteReg,
  output logic [3:0]    DstReg,
  output logic [DW-1:0] DstData,
  output logic          ex_valid,
  input  logic          ex_ready,
  output logic [3:0]    ex_op,
  output logic [3:0]    ex_rd,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [3:0]    ex_imm,
  output logic          ex_wr
);

  typedef struct packed {
    logic [3:0]    op;
    logic [3:0]    rd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    imm;
    logic          wr;
  } idex_t;

  idex_t            idex, idexNext;
  logic [NREGS-1:0] pending, pendNext;
  logic [3:0]       op, rd, rs, rt;
  logic             isAlu, isLw, isSw, decWr, useSrc2;
  logic             byp1, byp2, haz1, haz2, waw, stall, issue;

  assign op = in_instr[15:12];
  assign rd = in_instr[11:8];
  assign rs = in_instr[7:4];
  assign rt = in_instr[3:0];

  assign isAlu   = ~op[3];
  assign isLw    = (op == 4'b1000);
  assign isSw    = (op == 4'b1001);
  assign decWr   = (isAlu | isLw) && (rd != 4'd0);
  assign useSrc2 = isAlu | isSw;

  assign SrcReg1 = rs;
  assign SrcReg2 = isSw ? rd : rt;

  assign WriteReg = wb_en;
  assign DstReg   = wb_reg;
  assign DstData  = wb_data;

`ifdef WB_BYPASS_EN
  assign byp1 = wb_en && (wb_reg == SrcReg1) && (SrcReg1 != 4'd0);
  assign byp2 = wb_en && (wb_reg == SrcReg2) && (SrcReg2 != 4'd0);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // R0 never hazards; WAW is only resolved once the pending bit actually clears.
  assign haz1  = (SrcReg1 != 4'd0) && pending[SrcReg1] && !byp1;
  assign haz2  = useSrc2 && (SrcReg2 != 4'd0) && pending[SrcReg2] && !byp2;
  assign waw   = decWr && pending[rd];
  assign stall = in_valid && (haz1 || haz2 || waw);

  assign in_ready = !stall && !flush && (!ex_valid || ex_ready);
  assign issue    = in_valid && in_ready;

  always_comb begin
    idexNext.op  = op;
    idexNext.rd  = rd;
    idexNext.a   = byp1 ? wb_data : SrcData1;
    idexNext.b   = byp2 ? wb_data : SrcData2;
    idexNext.imm = rt;
    idexNext.wr  = decWr;
  end

  // Clears first, then the issue set, so a same-cycle set of the same register wins.
  always_comb begin
    pendNext = pending;
    if (wb_en) pendNext[wb_reg] = 1'b0;
    if (flush && ex_valid && idex.wr) pendNext[idex.rd] = 1'b0;
    if (issue && decWr) pendNext[rd] = 1'b1;
    pendNext[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pendNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      idex     <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (issue) begin
      ex_valid <= 1'b1;
      idex     <= idexNext;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  assign ex_op  = idex.op;
  assign ex_rd  = idex.rd;
  assign ex_a   = idex.a;
  assign ex_b   = idex.b;
  assign ex_imm = idex.imm;
  assign ex_wr  = idex.wr;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage with a behavioural register file feeding the read ports.
module tb_decode_issue_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, flush = 1'b0, wb_en = 1'b0, ex_ready = 1'b1;
  logic [15:0] in_instr = '0, wb_data = '0;
  logic [3:0]  wb_reg = '0;
  logic        in_ready, WriteReg, ex_valid, ex_wr;
  logic [3:0]  SrcReg1, SrcReg2, DstReg, ex_op, ex_rd, ex_imm;
  logic [15:0] SrcData1, SrcData2, DstData, ex_a, ex_b;
  logic [15:0] rf [16];
  int checks = 0, failures = 0;

  decode_issue_stage #(.NREGS(16), .DW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .SrcData1(SrcData1), .SrcData2(SrcData2),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .WriteReg(WriteReg), .DstReg(DstReg),
    .DstData(DstData), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_wr(ex_wr)
  );

  always #5 clk = ~clk;

  // Register file: R0 reads zero, write at posedge from the pass-through port.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'h0100 + 16'(i);
      rf[3] <= 16'd5;
      rf[4] <= 16'd7;
    end else if (WriteReg && DstReg != 4'd0) begin
      rf[DstReg] <= DstData;
    end
  end
  assign SrcData1 = (SrcReg1 == 4'd0) ? 16'd0 : rf[SrcReg1];
  assign SrcData2 = (SrcReg2 == 4'd0) ? 16'd0 : rf[SrcReg2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins);
    in_valid = v;
    in_instr = ins;
    #1;
  endtask

  task automatic wb(input logic en, input logic [3:0] r, input logic [15:0] d);
    wb_en = en; wb_reg = r; wb_data = d;
    #1;
  endtask

  initial begin
    // reset
    step(); step();
    chk("rst_valid", ex_valid, 0);
    chk("rst_a", ex_a, 0);
    chk("rst_wr", ex_wr, 0);
    chk("rst_op", ex_op, 0);
    rst = 1'b0;

    // basic ALU issue
    drive(1, 16'h0234);
    chk("t1_rdy", in_ready, 1);
    chk("t1_src1", SrcReg1, 3);
    chk("t1_src2", SrcReg2, 4);
    step();
    chk("t1_valid", ex_valid, 1);
    chk("t1_a", ex_a, 5);
    chk("t1_b", ex_b, 7);
    chk("t1_rd", ex_rd, 2);
    chk("t1_wr", ex_wr, 1);

    // RAW on R2 (rt = R0 never hazards)
    drive(1, 16'h0520);
    chk("raw_stall", in_ready, 0);
    step();
    chk("raw_bubble", ex_valid, 0);
    chk("raw_stall2", in_ready, 0);
    wb(1, 4'd2, 16'h00AA);
    chk("wb_pass_en", WriteReg, 1);
    chk("wb_pass_reg", DstReg, 2);
    chk("wb_pass_data", DstData, 16'h00AA);
`ifdef WB_BYPASS_EN
    chk("raw_byp_rdy", in_ready, 1);
    step();
    wb(0, 4'd0, 16'h0);
`else
    chk("raw_nobyp_rdy", in_ready, 0);
    step();
    wb(0, 4'd0, 16'h0);
    chk("raw_nobyp_bubble", ex_valid, 0);
    chk("raw_nobyp_rdy2", in_ready, 1);
    step();
`endif
    chk("raw_valid", ex_valid, 1);
    chk("raw_a", ex_a, 16'h00AA);
    chk("raw_rd", ex_rd, 5);
    drive(0, 16'h0);
    wb(1, 4'd5, 16'h0055);
    step();
    wb(0, 4'd0, 16'h0);

    // WAW on R6
    drive(1, 16'h0611);
    chk("waw_first_rdy", in_ready, 1);
    step();
    chk("waw_stall", in_ready, 0);
    step();
    chk("waw_stall2", in_ready, 0);
    wb(1, 4'd6, 16'h0066);
    chk("waw_wb_cycle", in_ready, 0);
    step();
    wb(0, 4'd0, 16'h0);
    chk("waw_rdy", in_ready, 1);
    step();
    chk("waw_valid", ex_valid, 1);
    chk("waw_rd", ex_rd, 6);
    drive(0, 16'h0);
    wb(1, 4'd6, 16'h0066);
    step();
    wb(0, 4'd0, 16'h0);

    // backpressure
    ex_ready = 1'b0;
    drive(1, 16'h1C89);
    step();
    chk("bp_valid", ex_valid, 1);
    chk("bp_imm", ex_imm, 9);
    drive(1, 16'h2A12);
    for (int i = 0; i < 3; i++) begin
      chk("bp_rdy", in_ready, 0);
      chk("bp_hold_valid", ex_valid, 1);
      chk("bp_hold_op", ex_op, 1);
      chk("bp_hold_rd", ex_rd, 12);
      chk("bp_hold_a", ex_a, 16'h0108);
      step();
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_release_rdy", in_ready, 1);
    step();
    chk("bp_next_op", ex_op, 2);
    chk("bp_next_rd", ex_rd, 10);
    chk("bp_next_a", ex_a, 16'h0101);
    chk("bp_next_b", ex_b, 16'h00AA);
    drive(0, 16'h0);
    step();
    chk("drain_valid", ex_valid, 0);

    // flush kills R9 producer and its pending bit
    drive(1, 16'h0933);
    step();
    chk("fl_valid", ex_valid, 1);
    chk("fl_rd", ex_rd, 9);
    flush = 1'b1;
    drive(1, 16'h0C44);
    chk("fl_rdy", in_ready, 0);
    step();
    flush = 1'b0;
    drive(1, 16'h0B90);
    chk("fl_killed", ex_valid, 0);
    chk("fl_r9_free", in_ready, 1);
    step();
    chk("fl_next_valid", ex_valid, 1);
    chk("fl_next_a", ex_a, 16'h0109);

    // SW: rd is a source, no write
    drive(1, 16'h9712);
    chk("sw_src1", SrcReg1, 1);
    chk("sw_src2", SrcReg2, 7);
    step();
    chk("sw_wr", ex_wr, 0);
    chk("sw_op", ex_op, 9);
    chk("sw_b", ex_b, 16'h0107);
    drive(1, 16'h0D70);
    chk("sw_no_pend", in_ready, 1);
    step();

    // rd = 0 never writes
    drive(1, 16'h0012);
    step();
    chk("r0_wr", ex_wr, 0);
    drive(1, 16'h0E00);
    chk("r0_src_rdy", in_ready, 1);
    step();

    // LW writes, read-only class hazards on rs
    drive(1, 16'h8F10);
    step();
    chk("lw_wr", ex_wr, 1);
    chk("lw_rd", ex_rd, 15);
    drive(1, 16'hA0F0);
    chk("ro_stall", in_ready, 0);
    step();

    // async reset mid-stall
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", ex_valid, 0);
    chk("arst_wr", ex_wr, 0);
    step();
    rst = 1'b0;
    #1;
    chk("arst_pend_clr", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
